// File: rtl/ray_frame_sequencer.sv
// Frame sequencer for the ray-march shading pipeline.
// Walks the screen in raster order and emits one fixed-point coordinate per issue.
// Holds a frozen copy of the scene configuration for the whole frame.
// Limits outstanding pixels with a credit counter so the output FIFO cannot overflow.
module ray_frame_sequencer #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int MAX_INFLIGHT = 64,
  parameter int CNT_W        = 10,
  parameter int FP_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_gen,
  input  logic                  start,
  input  logic                  abort,
  input  logic [FP_W-1:0]       cfg_x_start,
  input  logic [FP_W-1:0]       cfg_x_step,
  input  logic [FP_W-1:0]       cfg_y_start,
  input  logic [FP_W-1:0]       cfg_y_step,
  input  logic [3*FP_W-1:0]     cfg_light_pos,
  input  logic [3*FP_W-1:0]     cfg_camera_forward,
  input  logic [3*FP_W-1:0]     cfg_camera_right,
  input  logic [3*FP_W-1:0]     cfg_ray_origin,
  input  logic                  cfg_sdf_sel,
  input  logic                  downstream_ready,
  input  logic                  pixel_retired,
  output logic [FP_W-1:0]       screen_x,
  output logic [FP_W-1:0]       screen_y,
  output logic                  pix_valid,
  output logic [3*FP_W-1:0]     light_pos,
  output logic [3*FP_W-1:0]     camera_forward,
  output logic [3*FP_W-1:0]     camera_right,
  output logic [3*FP_W-1:0]     ray_origin,
  output logic                  sdf_sel,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      inflight
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  // Frame-constant scene snapshot; x_start/steps are kept for the raster walk.
  typedef struct packed {
    logic [3*FP_W-1:0] light_pos;
    logic [3*FP_W-1:0] camera_forward;
    logic [3*FP_W-1:0] camera_right;
    logic [3*FP_W-1:0] ray_origin;
    logic              sdf_sel;
    logic [FP_W-1:0]   x_start;
    logic [FP_W-1:0]   x_step;
    logic [FP_W-1:0]   y_step;
  } scene_t;

  state_t           state_q, state_d;
  scene_t           shadow_q, shadow_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [FP_W-1:0]  sx_q, sx_d;
  logic [FP_W-1:0]  sy_q, sy_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             aborted_q, aborted_d;
  logic             issue;
  logic             retire_eff;
  logic             last_col;
  logic             last_row;

  assign last_col   = (col_q == COL_W'(H_RES - 1));
  assign last_row   = (row_q == ROW_W'(V_RES - 1));
  // A retire with nothing outstanding is spurious and must not underflow.
  assign retire_eff = pixel_retired && (inflight_q != '0);

  // Frame FSM, raster walk and config capture.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    col_d     = col_q;
    row_d     = row_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    aborted_d = aborted_q;
    issue     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        shadow_d.light_pos      = cfg_light_pos;
        shadow_d.camera_forward = cfg_camera_forward;
        shadow_d.camera_right   = cfg_camera_right;
        shadow_d.ray_origin     = cfg_ray_origin;
        shadow_d.sdf_sel        = cfg_sdf_sel;
        shadow_d.x_start        = cfg_x_start;
        shadow_d.x_step         = cfg_x_step;
        shadow_d.y_step         = cfg_y_step;
        col_d     = '0;
        row_d     = '0;
        sx_d      = cfg_x_start;
        sy_d      = cfg_y_start;
        aborted_d = 1'b0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        // A same-cycle retire frees a slot, so a full counter can still issue.
        issue = downstream_ready &&
                ((inflight_q < CNT_W'(MAX_INFLIGHT)) || pixel_retired);
        if (issue) begin
          if (last_col) begin
            col_d = '0;
            sx_d  = shadow_q.x_start;
            row_d = row_q + ROW_W'(1);
            sy_d  = sy_q + shadow_q.y_step;
            if (last_row) state_d = S_DRAIN;
          end else begin
            col_d = col_q + COL_W'(1);
            sx_d  = sx_q + shadow_q.x_step;
          end
        end
        // Abort stops further issue; the pixel issued this cycle still counts.
        if (abort) begin
          state_d   = S_DRAIN;
          aborted_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Credit counter: issue and retire in the same cycle cancel out.
  always_comb begin
    inflight_d = inflight_q;
    case ({issue, retire_eff})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst_gen) begin
    if (rst_gen) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      inflight_q <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      col_q      <= col_d;
      row_q      <= row_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      inflight_q <= inflight_d;
      aborted_q  <= aborted_d;
    end
  end

  assign screen_x       = sx_q;
  assign screen_y       = sy_q;
  assign pix_valid      = issue;
  assign light_pos      = shadow_q.light_pos;
  assign camera_forward = shadow_q.camera_forward;
  assign camera_right   = shadow_q.camera_right;
  assign ray_origin     = shadow_q.ray_origin;
  assign sdf_sel        = shadow_q.sdf_sel;
  assign busy           = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign frame_done     = (state_q == S_DONE);
  assign aborted        = aborted_q;
  assign inflight       = inflight_q;

endmodule

// File: tb/tb_ray_frame_sequencer.sv
// Scoreboard bench for ray_frame_sequencer on a 4x3 screen with 6 credits.
module tb_ray_frame_sequencer;

  localparam int FP_W = 16;
  localparam int CNT_W = 10;

  logic              clk, rst_gen, start, abort;
  logic [FP_W-1:0]   cfg_x_start, cfg_x_step, cfg_y_start, cfg_y_step;
  logic [3*FP_W-1:0] cfg_light_pos, cfg_camera_forward, cfg_camera_right, cfg_ray_origin;
  logic              cfg_sdf_sel, downstream_ready, pixel_retired;
  logic [FP_W-1:0]   screen_x, screen_y;
  logic              pix_valid;
  logic [3*FP_W-1:0] light_pos, camera_forward, camera_right, ray_origin;
  logic              sdf_sel, busy, frame_done, aborted;
  logic [CNT_W-1:0]  inflight;

  ray_frame_sequencer #(.H_RES(4), .V_RES(3), .MAX_INFLIGHT(6), .CNT_W(CNT_W), .FP_W(FP_W)) dut (
    .clk(clk), .rst_gen(rst_gen), .start(start), .abort(abort),
    .cfg_x_start(cfg_x_start), .cfg_x_step(cfg_x_step),
    .cfg_y_start(cfg_y_start), .cfg_y_step(cfg_y_step),
    .cfg_light_pos(cfg_light_pos), .cfg_camera_forward(cfg_camera_forward),
    .cfg_camera_right(cfg_camera_right), .cfg_ray_origin(cfg_ray_origin),
    .cfg_sdf_sel(cfg_sdf_sel), .downstream_ready(downstream_ready),
    .pixel_retired(pixel_retired), .screen_x(screen_x), .screen_y(screen_y),
    .pix_valid(pix_valid), .light_pos(light_pos), .camera_forward(camera_forward),
    .camera_right(camera_right), .ray_origin(ray_origin), .sdf_sel(sdf_sel),
    .busy(busy), .frame_done(frame_done), .aborted(aborted), .inflight(inflight)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_cyc = -1;
  int last_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int issue_cnt = 0;
  int sc = 0;
  logic        last_issue = 1'b0;
  logic        auto_ret = 1'b0;
  logic        man_ret = 1'b0;
  logic [7:0]  hist = '0;
  logic [31:0] exp_q[$];
  logic        done_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected coordinate of raster index k is start + step*col / start + step*row.
  task automatic push_frame(input logic [15:0] xs, input logic [15:0] xst,
                            input logic [15:0] ys, input logic [15:0] yst,
                            input int k0, input int n);
    logic [15:0] x, y;
    for (int k = k0; k < k0 + n; k++) begin
      x = xs + xst * 16'(k % 4);
      y = ys + yst * 16'(k / 4);
      exp_q.push_back({x, y});
    end
  endtask

  task automatic set_cfg(input logic [15:0] xs, input logic [15:0] xst,
                         input logic [15:0] ys, input logic [15:0] yst,
                         input logic [47:0] cf);
    cfg_x_start = xs; cfg_x_step = xst; cfg_y_start = ys; cfg_y_step = yst;
    cfg_camera_forward = cf;
  endtask

  task automatic start_frame();
    tick();
    start = 1'b1;
    sc = cyc;
    first_cyc = -1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    for (int i = 0; i < 300 && done_cnt == n0; i++) tick();
    chk("frame_done_seen", 64'(done_cnt != n0), 64'd1);
  endtask

  // Retire generator: auto mode retires each pixel 5 cycles after its issue.
  initial forever begin
    @(posedge clk);
    #2;
    hist = {hist[6:0], last_issue};
    pixel_retired = auto_ret ? hist[4] : man_ret;
  end

  // Monitor: pops the scoreboard on every issue and every frame end.
  initial forever begin
    logic [31:0] e;
    logic        d;
    @(negedge clk);
    last_issue = pix_valid;
    if (pix_valid) begin
      issue_cnt++;
      last_cyc = cyc;
      if (first_cyc < 0) first_cyc = cyc;
      chk("ready_at_issue", 64'(downstream_ready), 64'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel act=%0h,%0h exp=none", screen_x, screen_y);
      end else begin
        e = exp_q.pop_front();
        chk("pix_x", 64'(screen_x), 64'(e[31:16]));
        chk("pix_y", 64'(screen_y), 64'(e[15:0]));
      end
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done act=1 exp=0");
      end else begin
        d = done_q.pop_front();
        chk("aborted_at_done", 64'(aborted), 64'(d));
      end
    end
  end

  initial begin
    int n0, ic0;
    rst_gen = 1'b1; start = 1'b0; abort = 1'b0; downstream_ready = 1'b1;
    pixel_retired = 1'b0; cfg_sdf_sel = 1'b1;
    cfg_light_pos = 48'h0A0A_0B0B_0C0C; cfg_camera_right = 48'h0001_0002_0003;
    cfg_ray_origin = 48'h0100_0200_0300;
    set_cfg(16'h0000, 16'h0100, 16'h0000, 16'h0100, 48'h1111_2222_3333);

    // Reset state
    @(negedge clk);
    chk("rst_pix_valid", 64'(pix_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_cam_fwd", 64'(camera_forward), 64'd0);
    tick(); tick();
    rst_gen = 1'b0;
    tick();

    // Full 4x3 frame, retire 5 cycles after issue
    auto_ret = 1'b1;
    push_frame(16'h0000, 16'h0100, 16'h0000, 16'h0100, 0, 12);
    done_q.push_back(1'b0);
    n0 = done_cnt;
    start_frame();
    wait_done(n0);
    chk("f1_latency", 64'(first_cyc - sc), 64'd2);
    chk("f1_back_to_back", 64'(last_cyc - first_cyc), 64'd11);
    chk("f1_done_time", 64'(done_cyc - last_cyc), 64'd7);
    chk("f1_cam_fwd", 64'(camera_forward), 64'h1111_2222_3333);
    chk("f1_light", 64'(light_pos), 64'h0A0A_0B0B_0C0C);
    chk("f1_sdf", 64'(sdf_sel), 64'd1);
    tick();
    chk("f1_idle_busy", 64'(busy), 64'd0);

    // Ready toggling and mid-frame config changes
    set_cfg(16'h0000, 16'h0100, 16'h0000, 16'h0100, 48'hAAAA_BBBB_CCCC);
    push_frame(16'h0000, 16'h0100, 16'h0000, 16'h0100, 0, 12);
    done_q.push_back(1'b0);
    n0 = done_cnt;
    start_frame();
    for (int i = 0; i < 200 && done_cnt == n0; i++) begin
      tick();
      downstream_ready = ~downstream_ready;
      if (i == 4) begin
        cfg_x_step = 16'h0300;
        cfg_camera_forward = 48'h5555_6666_7777;
      end
    end
    downstream_ready = 1'b1;
    chk("f2_done_seen", 64'(done_cnt - n0), 64'd1);
    chk("f2_cam_frozen", 64'(camera_forward), 64'hAAAA_BBBB_CCCC);

    // Abort after 5 issues with 3 outstanding
    auto_ret = 1'b0;
    man_ret = 1'b0;
    set_cfg(16'h0000, 16'h0100, 16'h0000, 16'h0100, 48'h1111_2222_3333);
    push_frame(16'h0000, 16'h0100, 16'h0000, 16'h0100, 0, 5);
    done_q.push_back(1'b1);
    n0 = done_cnt;
    start_frame();
    for (int i = 0; i < 5; i++) begin
      tick();
      man_ret = (i == 2 || i == 3);
      abort = (i == 4);
    end
    tick();
    man_ret = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_inflight", 64'(inflight), 64'd3);
    chk("abort_busy", 64'(busy), 64'd1);
    for (int i = 6; i < 10; i++) begin
      tick();
      man_ret = (i >= 7);
    end
    tick();
    man_ret = 1'b0;
    wait_done(n0);
    chk("abort_done_time", 64'(done_cyc - sc), 64'd13);
    chk("abort_sticky", 64'(aborted), 64'd1);

    // Negative x step, wrapping y; next start clears aborted
    auto_ret = 1'b1;
    set_cfg(16'h0500, 16'hFF80, 16'hFF00, 16'h0100, 48'h0123_4567_89AB);
    push_frame(16'h0500, 16'hFF80, 16'hFF00, 16'h0100, 0, 12);
    done_q.push_back(1'b0);
    n0 = done_cnt;
    start_frame();
    tick();
    @(negedge clk);
    chk("aborted_cleared", 64'(aborted), 64'd0);
    wait_done(n0);
    chk("f3_cam_fwd", 64'(camera_forward), 64'h0123_4567_89AB);

    // Credit limit with no retires, then async reset mid-frame
    auto_ret = 1'b0;
    man_ret = 1'b0;
    set_cfg(16'h1000, 16'h0100, 16'h2000, 16'h0100, 48'h0F0F_0F0F_0F0F);
    push_frame(16'h1000, 16'h0100, 16'h2000, 16'h0100, 0, 6);
    ic0 = issue_cnt;
    start_frame();
    repeat (12) tick();
    @(negedge clk);
    chk("credit_full", 64'(inflight), 64'd6);
    chk("credit_issues", 64'(issue_cnt - ic0), 64'd6);
    tick();
    man_ret = 1'b1;
    push_frame(16'h1000, 16'h0100, 16'h2000, 16'h0100, 6, 1);
    @(negedge clk);
    chk("issue_on_retire", 64'(pix_valid), 64'd1);
    tick();
    man_ret = 1'b0;
    @(negedge clk);
    chk("hold_at_max", 64'(inflight), 64'd6);
    chk("stall_again", 64'(pix_valid), 64'd0);
    tick();
    downstream_ready = 1'b0;
    man_ret = 1'b1;
    tick();
    tick();
    man_ret = 1'b0;
    @(negedge clk);
    chk("credit_dec", 64'(inflight), 64'd4);
    #2;
    downstream_ready = 1'b1;
    rst_gen = 1'b1;
    #1;
    chk("arst_pix_valid", 64'(pix_valid), 64'd0);
    chk("arst_inflight", 64'(inflight), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_screen_x", 64'(screen_x), 64'd0);
    chk("arst_screen_y", 64'(screen_y), 64'd0);
    chk("arst_cam_fwd", 64'(camera_forward), 64'd0);
    tick();
    tick();
    rst_gen = 1'b0;
    repeat (10) tick();

    // Fresh frame after reset starts at (x_start, y_start)
    auto_ret = 1'b1;
    set_cfg(16'h0300, 16'h0040, 16'h0700, 16'hFFC0, 48'h7777_8888_9999);
    push_frame(16'h0300, 16'h0040, 16'h0700, 16'hFFC0, 0, 12);
    done_q.push_back(1'b0);
    n0 = done_cnt;
    start_frame();
    wait_done(n0);
    chk("f4_latency", 64'(first_cyc - sc), 64'd2);

    repeat (3) tick();
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
